// File: rtl/gsr_req_seq.sv
// Reset-request sequencer driving the active-low GSR input of the downstream GSR release synchronizer.
// Optional immediate software request path compiled in with GSRSEQ_SWREQ_EN.
module gsr_req_seq #(
  parameter int unsigned DEB_CYC   = 16,
  parameter int unsigned HOLD_CYC  = 64,
  parameter int unsigned GUARD_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
`ifdef GSRSEQ_SWREQ_EN
  input  logic       swreq,
`endif
  output logic       gsr,
  output logic       busy,
  output logic       done,
  output logic [7:0] evt_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    ASSERT   = 2'd2,
    GUARD    = 2'd3
  } state_t;

  localparam logic [15:0] DEB_LAST   = 16'(DEB_CYC - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYC - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        evt_inc;
  logic        req_s1, req_s;
  logic        sw_go;

`ifdef GSRSEQ_SWREQ_EN
  assign sw_go = swreq;
`else
  assign sw_go = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous external request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_s1 <= 1'b0;
      req_s  <= 1'b0;
    end else begin
      req_s1 <= req;
      req_s  <= req_s1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    evt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (sw_go) begin
          state_nxt = ASSERT;
          cnt_nxt   = 16'd0;
          evt_inc   = 1'b1;
        end else if (req_s) begin
          state_nxt = DEBOUNCE;
          cnt_nxt   = 16'd0;
        end
      end
      DEBOUNCE: begin
        if (sw_go) begin
          state_nxt = ASSERT;
          cnt_nxt   = 16'd0;
          evt_inc   = 1'b1;
        end else if (!req_s) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = ASSERT;
          cnt_nxt   = 16'd0;
          evt_inc   = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ASSERT: begin
        // Counter parks at the last hold cycle while the request is still high
        if (cnt == HOLD_LAST) begin
          if (!req_s) begin
            state_nxt = GUARD;
            cnt_nxt   = 16'd0;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = ASSERT;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  // State, counter and registered outputs; reset re-enters the hold phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ASSERT;
      cnt     <= 16'd0;
      gsr     <= 1'b0;
      busy    <= 1'b1;
      done    <= 1'b0;
      evt_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      gsr   <= (state_nxt != ASSERT);
      busy  <= (state_nxt != IDLE);
      done  <= (state == GUARD) && (state_nxt == IDLE);
      if (evt_inc) begin
        evt_cnt <= sat_inc8(evt_cnt);
      end
    end
  end

endmodule

// File: tb/tb_gsr_req_seq.sv
// Scoreboard bench for gsr_req_seq: a timestamp/window reference model predicts outputs per edge,
// a separate monitor pops and compares after every rising edge.
module tb_gsr_req_seq;

  localparam int DEB   = 16;
  localparam int HOLD  = 64;
  localparam int GUARD = 8;
`ifdef GSRSEQ_SWREQ_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       req;
  logic       swreq;
  logic       gsr;
  logic       busy;
  logic       done;
  logic [7:0] evt_cnt;

  gsr_req_seq #(
    .DEB_CYC  (DEB),
    .HOLD_CYC (HOLD),
    .GUARD_CYC(GUARD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
`ifdef GSRSEQ_SWREQ_EN
    .swreq  (swreq),
`endif
    .gsr    (gsr),
    .busy   (busy),
    .done   (done),
    .evt_cnt(evt_cnt)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       gsr;
    logic       busy;
    logic       done;
    logic [7:0] evt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  // Reference model: edges numbered from reset release, phases kept as entry timestamps
  int k;
  int t_asr, t_grd, t_idl;
  int evt;
  bit req_at[$];

  function automatic bit seen(int j);
    return (j >= 3) ? req_at[j-2] : 1'b0;
  endfunction

  function automatic bit in_asr();
    return (t_asr > t_grd) && (t_asr > t_idl);
  endfunction

  function automatic bit in_grd();
    return !in_asr() && (t_grd > t_idl);
  endfunction

  function automatic bit window_high(int kk);
    for (int j = kk - DEB; j <= kk; j++) begin
      if (!seen(j)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic enter_assert();
    t_asr = k;
    evt   = (evt == 255) ? 255 : evt + 1;
  endtask

  task automatic step(input bit r, input bit s, input bit rs);
    exp_t e;
    bit   sv;
    @(negedge clk);
    req   = r;
    swreq = s;
    rst   = rs;
    if (rs) begin
      k = 0; t_asr = 0; t_grd = -1; t_idl = -1; evt = 0;
      req_at.delete();
      req_at.push_back(1'b0);
      e.gsr = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.evt = 8'd0;
    end else begin
      k++;
      req_at.push_back(r);
      sv = seen(k);
      if (in_asr()) begin
        if ((k - t_asr >= HOLD) && !sv) t_grd = k;
      end else if (in_grd()) begin
        if (k - t_grd == GUARD) t_idl = k;
      end else begin
        if (SW_EN && s) enter_assert();
        else if ((k - DEB >= t_idl + 1) && window_high(k)) enter_assert();
      end
      e.gsr  = !in_asr();
      e.busy = in_asr() || in_grd() || ((t_idl < k) && sv);
      e.done = (t_idl == k);
      e.evt  = 8'(evt);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic req_burst(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1, 1'b0, 1'b0);
    idle_steps(lo);
  endtask

  task automatic until_idle(input int budget);
    int n;
    n = 0;
    while ((in_asr() || in_grd()) && n < budget) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (in_asr() || in_grd()) begin
      n_chk++;
      $display("FAIL idle_wait cyc=%0d got=busy required=idle within %0d", cyc, budget);
    end
  endtask

  // Monitor: compares whatever the stimulus side predicted for this edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (gsr === e.gsr) n_pass++;
        else $display("FAIL gsr cyc=%0d got=%b required=%b", cyc, gsr, e.gsr);
        n_chk++;
        if (busy === e.busy) n_pass++;
        else $display("FAIL busy cyc=%0d got=%b required=%b", cyc, busy, e.busy);
        n_chk++;
        if (done === e.done) n_pass++;
        else $display("FAIL done cyc=%0d got=%b required=%b", cyc, done, e.done);
        n_chk++;
        if (evt_cnt === e.evt) n_pass++;
        else $display("FAIL evt_cnt cyc=%0d got=%0d required=%0d", cyc, evt_cnt, e.evt);
      end
    end
  end

  initial begin
    int hi, lo, n;
    rst = 1'b1; req = 1'b0; swreq = 1'b0;
    k = 0; t_asr = 0; t_grd = -1; t_idl = -1; evt = 0;
    req_at.push_back(1'b0);

    // Power-on reset, then post-reset hold and guard with no request
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    idle_steps(80);

    // Long request released before hold ends, glitch, extended request
    req_burst(40, 120);
    req_burst(10, 40);
    req_burst(200, 100);

    // Randomized request bursts
    for (int b = 0; b < 40; b++) begin
      hi = $urandom_range(1, 40);
      lo = $urandom_range(1, 120);
      for (int i = 0; i < hi; i++) step(1'b1, SW_EN && ($urandom_range(0, 63) == 0), 1'b0);
      for (int i = 0; i < lo; i++) step(1'b0, SW_EN && ($urandom_range(0, 63) == 0), 1'b0);
    end

    // Reset in the middle of a debounced assertion
    until_idle(400);
    idle_steps(5);
    n = 0;
    while (!in_asr() && n < 100) begin
      step(1'b1, 1'b0, 1'b0);
      n++;
    end
    idle_steps(10);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    idle_steps(90);

`ifdef GSRSEQ_SWREQ_EN
    // Software request from idle; a second one during guard is ignored
    until_idle(400);
    idle_steps(4);
    step(1'b0, 1'b1, 1'b0);
    idle_steps(66);
    step(1'b0, 1'b1, 1'b0);
    idle_steps(20);

    // Back-to-back software events until the event counter saturates
    for (int i = 0; i < 300; i++) begin
      until_idle(200);
      step(1'b0, 1'b1, 1'b0);
    end
    idle_steps(10);
    step(1'b0, 1'b0, 1'b1);
    idle_steps(80);
`endif

    step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gsr_req_seq.md
# gsr_req_seq

Reset-request sequencer that drives the active-low global set/reset input of the synchronous GSR release primitive. Accepts an asynchronous external reset request and an optional single-cycle software request, debounces the external request, and asserts GSR for a guaranteed minimum hold time. After each release it enforces a guard interval. Sits directly upstream of the GSR synchronizer: its GSR output connects to that primitive's GSR input on the same CLK.

## Interface
- DEB_CYC, 16, consecutive synchronized high samples of REQ required before asserting GSR (1..65535)
- HOLD_CYC, 64, minimum cycles GSR is held low per event (1..65535)
- GUARD_CYC, 8, cycles after GSR release during which all requests are ignored (1..65535)
- CLK  input  1  sole clock; all state on rising edge
- RST  input  1  asynchronous, active-high reset; deassertion must meet recovery/removal to CLK
- REQ  input  1  asynchronous external reset request, active-high level
- SWREQ  input  1  synchronous single-cycle software request, active-high (present only with GSRSEQ_SWREQ_EN)
- GSR  output  1  active-low global set/reset to downstream synchronizer, registered
- BUSY  output  1  high whenever state is not IDLE
- DONE  output  1  one-cycle pulse on GUARD -> IDLE
- EVT_CNT  output  8  saturating count of requested GSR events

## Operation
- REQ passes a 2-flop synchronizer -> REQ_s; only REQ_s is used by the FSM.
- States: IDLE, DEBOUNCE, ASSERT, GUARD. One shared 16-bit counter.
- Reset values (RST high): state ASSERT, counter 0, GSR 0, BUSY 1, DONE 0, EVT_CNT 0, sync flops 0.
- IDLE: REQ_s=1 -> DEBOUNCE, counter 0.
- DEBOUNCE: REQ_s=0 -> IDLE; else counter++; at DEB_CYC-th consecutive high sample -> ASSERT.
- ASSERT: counter counts cycles in state; after HOLD_CYC cycles, if REQ_s=0 -> GUARD, else remain (extend) until REQ_s=0, then -> GUARD.
- GUARD: REQ and SWREQ ignored; after GUARD_CYC cycles -> IDLE, DONE pulses.
- GSR registered from next-state: low exactly while state is ASSERT.
- EVT_CNT increments on every IDLE/DEBOUNCE -> ASSERT transition; saturates at 255; the post-RST ASSERT does not count.
- SWREQ (if compiled in): high at edge in IDLE or DEBOUNCE -> ASSERT on that edge, no debounce; ignored in ASSERT/GUARD; never extends hold. SWREQ and REQ_s together: SWREQ wins.

## Timing
- Post-reset: first rising edge after RST release is hold cycle 1; GSR rises at edge HOLD_CYC, then GUARD_CYC cycles of GUARD, then IDLE.
- REQ rising, first seen at edge 1: REQ_s high at edge 2, DEBOUNCE at edge 3, GSR low at edge 3+DEB_CYC (defaults: edge 19).
- REQ glitch shorter than DEB_CYC synchronized samples: no GSR assertion, return to IDLE.
- GSR low duration: exactly HOLD_CYC cycles if REQ_s low by the final hold cycle; otherwise until the edge after REQ_s is seen low.
- DONE high for exactly one cycle, starting at the edge that enters IDLE; BUSY low in that same cycle.
- RST mid-operation: asynchronous to reset values immediately (GSR forced low), restarting the post-reset hold.
- Counter never wraps; parameters outside 1..65535 are illegal.

## Configuration
- GSRSEQ_SWREQ_EN defined: SWREQ port and immediate-assert path present.
- Undefined: no SWREQ port; only REQ (debounced) and RST cause GSR assertion; EVT_CNT counts REQ events only.

## Test plan
- RST pulse, REQ=0, defaults -> GSR=0 during RST and for 64 edges after release; GSR=1 at edge 64; DONE pulse at edge 72; EVT_CNT=0.
- From IDLE, REQ held high 40 cycles -> GSR falls at edge 19, stays low 64 cycles, GUARD 8, DONE pulse; EVT_CNT=1.
- REQ high 10 cycles (DEB_CYC=16) -> GSR stays 1, BUSY returns low, EVT_CNT unchanged.
- REQ held high 200 cycles -> GSR low until the edge after REQ_s is seen low, then GUARD 8 cycles.
- GSRSEQ_SWREQ_EN: SWREQ pulse in IDLE -> GSR low at that edge for 64 cycles; second SWREQ during GUARD ignored.
- 300 back-to-back SWREQ events -> EVT_CNT saturates at 255; RST mid-ASSERT -> GSR held low, EVT_CNT=0.
